pdm_audio_ctrl: RTL and testbench

- Controller for the PDM microphone data pad: generates the PDM bit clock from the system clock and sequences idle/warm-up/run.
- Samples the pad-registered PDM bit once per PDM clock period and decimates by ones-counting over DECIM bits.
- Presents each count as a PCM sample on a valid/ready interface to the bus-side FIFO or DMA.
- o_pdm_clk drives both the microphone clock pin and the data pad's input-register clock.

---
 rtl/pdm_audio_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pdm_audio_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_ctrl.sv
// rtl/pdm_audio_ctrl.sv - PDM microphone clock generator, warm-up sequencer and ones-count decimator
// Produces one CNT_W-bit PCM sample per DECIM PDM bits on a valid/ready output register.
module pdm_audio_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int DECIM   = 64,
  parameter int WARMUP  = 1024,
  parameter int CNT_W   = 7
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic             o_pdm_clk,
  input  logic             i_pdm_data_r,
  output logic [CNT_W-1:0] o_sample,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun,
  input  logic             i_clr_overrun,
  output logic             o_running
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int BIT_W  = $clog2(DECIM);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARM   = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                pdm_clk_q, pdm_clk_d;
  logic [CNT_W-1:0]    sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                running_q, running_d;

  logic                strobe;
  logic                complete;
  logic [CNT_W-1:0]    sample_sum;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    warm_cnt_d = warm_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    complete   = 1'b0;
    strobe     = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    sample_sum = acc_q + CNT_W'(i_pdm_data_r);

    if (state_q != IDLE) begin
      div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        warm_cnt_d = '0;
        bit_cnt_d  = '0;
        acc_d      = '0;
        if (i_enable) begin
          state_d = WARM;
        end
      end
      WARM: begin
        // Bits during warm-up are meaningless; only the strobes are counted.
        if (strobe) begin
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = '0;
            state_d    = RUN;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (strobe) begin
          if (bit_cnt_q == BIT_LAST) begin
            complete  = 1'b1;
            acc_d     = '0;
            bit_cnt_d = '0;
          end else begin
            acc_d     = sample_sum;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!i_enable) begin
      state_d    = IDLE;
      div_cnt_d  = '0;
      warm_cnt_d = '0;
      bit_cnt_d  = '0;
      acc_d      = '0;
    end

    pdm_clk_d = (state_d != IDLE) && (div_cnt_d < DIV_HALF);
    running_d = (state_d == RUN);
  end

  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q && !i_ready;
    overrun_d = i_clr_overrun ? 1'b0 : overrun_q;
    // Accept-and-reload in the same cycle is a clean hand-off, not a drop.
    if (complete) begin
      if (!valid_q || i_ready) begin
        sample_d = sample_sum;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      pdm_clk_q  <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      pdm_clk_q  <= pdm_clk_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      running_q  <= running_d;
    end
  end

  assign o_pdm_clk = pdm_clk_q;
  assign o_sample  = sample_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;
  assign o_running = running_q;

endmodule

// File: tb/tb_pdm_audio_ctrl.sv
// tb/tb_pdm_audio_ctrl.sv - directed bench for pdm_audio_ctrl (CLK_DIV=8, DECIM=64, WARMUP=4)
// A pad model registers a pattern bit on each o_pdm_clk rise; k counts cycles since enable.
module tb_pdm_audio_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pdm_clk;
  logic       pdm_data_r = 1'b0;
  logic [6:0] sample;
  logic       valid;
  logic       ready = 1'b1;
  logic       overrun;
  logic       clr = 1'b0;
  logic       running;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cnt = 0;
  int pad_idx = 0;
  int mode = 1;
  int r0 = 0;

  pdm_audio_ctrl #(.CLK_DIV(8), .DECIM(64), .WARMUP(4), .CNT_W(7)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .o_pdm_clk(pdm_clk),
    .i_pdm_data_r(pdm_data_r), .o_sample(sample), .o_valid(valid),
    .i_ready(ready), .o_overrun(overrun), .i_clr_overrun(clr), .o_running(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge pdm_clk) begin
    rise_cnt = rise_cnt + 1;
    pad_idx  = pad_idx + 1;
    case (mode)
      0:       pdm_data_r = 1'b0;
      1:       pdm_data_r = 1'b1;
      2:       pdm_data_r = pad_idx[0];
      default: pdm_data_r = (pad_idx[1:0] != 2'd0);
    endcase
  end

  task automatic wait_until(input int kk);
    while (cyc - t0 < kk) @(negedge clk);
  endtask

  task automatic start_enable();
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL rst_pdm_clk got=%b exp=0", pdm_clk); end
    checks++; if (sample !== 7'd0) begin errors++; $display("FAIL rst_sample got=%0d exp=0", sample); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (20) @(negedge clk);
    checks++; if (rise_cnt !== r0) begin errors++; $display("FAIL idle_no_edges got=%0d exp=%0d", rise_cnt, r0); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running got=%b exp=0", running); end
  endtask

  task automatic test_clocking();
    logic exp_clk;
    mode = 1;
    ready = 1'b1;
    start_enable();
    for (int kk = 1; kk <= 40; kk++) begin
      wait_until(kk);
      exp_clk = (((kk - 1) % 8) < 4);
      checks++; if (pdm_clk !== exp_clk) begin errors++; $display("FAIL clk_shape k=%0d got=%b exp=%b", kk, pdm_clk, exp_clk); end
      checks++; if (running !== (kk >= 33)) begin errors++; $display("FAIL running_rise k=%0d got=%b exp=%b", kk, running, (kk >= 33)); end
    end
  endtask

  task automatic test_constant();
    wait_until(544);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got=%b exp=0", valid); end
    wait_until(545);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", valid); end
    checks++; if (sample !== 7'd64) begin errors++; $display("FAIL ones_sample got=%0d exp=64", sample); end
    wait_until(546);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL accept_clears got=%b exp=0", valid); end
    wait_until(1050);
    mode = 0;
    wait_until(1056);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rate_early got=%b exp=0", valid); end
    wait_until(1057);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rate_valid got=%b exp=1", valid); end
    checks++; if (sample !== 7'd64) begin errors++; $display("FAIL second_sample got=%0d exp=64", sample); end
    wait_until(1569);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", valid); end
    checks++; if (sample !== 7'd0) begin errors++; $display("FAIL zeros_sample got=%0d exp=0", sample); end
    wait_until(1570);
    enable = 1'b0;
  endtask

  task automatic test_patterns();
    repeat (2) @(negedge clk);
    mode = 2;
    start_enable();
    while (!valid && (cyc - t0) < 700) @(negedge clk);
    checks++; if ((cyc - t0) !== 545) begin errors++; $display("FAIL alt_latency got=%0d exp=545", cyc - t0); end
    checks++; if (sample !== 7'd32) begin errors++; $display("FAIL alt_sample got=%0d exp=32", sample); end
    wait_until(546);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    mode = 3;
    start_enable();
    while (!valid && (cyc - t0) < 700) @(negedge clk);
    checks++; if ((cyc - t0) !== 545) begin errors++; $display("FAIL p31_latency got=%0d exp=545", cyc - t0); end
    checks++; if (sample !== 7'd48) begin errors++; $display("FAIL p31_sample got=%0d exp=48", sample); end
  endtask

  task automatic test_backpressure();
    wait_until(546);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got=%b exp=0", valid); end
    wait_until(1057);
    checks++; if (valid !== 1'b1 || sample !== 7'd48) begin errors++; $display("FAIL bp_held_load got=%b/%0d exp=1/48", valid, sample); end
    wait_until(1100);
    mode = 1;
    wait_until(1568);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_early got=%b exp=0", overrun); end
    wait_until(1569);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    checks++; if (valid !== 1'b1 || sample !== 7'd48) begin errors++; $display("FAIL bp_sample_kept got=%b/%0d exp=1/48", valid, sample); end
    wait_until(1600);
    clr = 1'b1;
    wait_until(1601);
    clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got=%b exp=0", overrun); end
    wait_until(2080);
    clr = 1'b1;
    wait_until(2081);
    clr = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", overrun); end
    checks++; if (sample !== 7'd48) begin errors++; $display("FAIL bp_sample_still got=%0d exp=48", sample); end
    wait_until(2100);
    ready = 1'b1;
    wait_until(2101);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", valid); end
  endtask

  task automatic test_disable();
    wait_until(2593);
    checks++; if (valid !== 1'b1 || sample !== 7'd64) begin errors++; $display("FAIL dis_pending got=%b/%0d exp=1/64", valid, sample); end
    wait_until(2833);
    checks++; if (pdm_clk !== 1'b1) begin errors++; $display("FAIL dis_clk_before got=%b exp=1", pdm_clk); end
    enable = 1'b0;
    wait_until(2834);
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL dis_clk_low got=%b exp=0", pdm_clk); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL dis_running got=%b exp=0", running); end
    wait_until(2854);
    checks++; if (valid !== 1'b1 || sample !== 7'd64) begin errors++; $display("FAIL dis_kept got=%b/%0d exp=1/64", valid, sample); end
    ready = 1'b1;
    wait_until(2855);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dis_accept got=%b exp=0", valid); end
    start_enable();
    wait_until(32);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reen_warm got=%b exp=0", running); end
    wait_until(33);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reen_run got=%b exp=1", running); end
    wait_until(544);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reen_early got=%b exp=0", valid); end
    wait_until(545);
    checks++; if (valid !== 1'b1 || sample !== 7'd64) begin errors++; $display("FAIL reen_sample got=%b/%0d exp=1/64", valid, sample); end
  endtask

  task automatic test_async_reset();
    wait_until(561);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL arst_pdm_clk got=%b exp=0", pdm_clk); end
    checks++; if (valid !== 1'b0 || sample !== 7'd0) begin errors++; $display("FAIL arst_output got=%b/%0d exp=0/0", valid, sample); end
    checks++; if (overrun !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL arst_flags got=%b/%b exp=0/0", overrun, running); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (20) @(negedge clk);
    checks++; if (rise_cnt !== r0) begin errors++; $display("FAIL arst_no_edges got=%0d exp=%0d", rise_cnt, r0); end
    start_enable();
    wait_until(1);
    checks++; if (pdm_clk !== 1'b1 || rise_cnt !== r0 + 1) begin errors++; $display("FAIL arst_restart got=%b/%0d exp=1/%0d", pdm_clk, rise_cnt, r0 + 1); end
  endtask

  initial begin
    test_reset();
    test_clocking();
    test_constant();
    test_patterns();
    test_backpressure();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
